mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single backing-memory port between the I-cache (line-fill reads) and D-cache (fills/writebacks).
//  Sits between both cache request paths and the memory model. Serialises one transaction at a time.
//  Fixed D-over-I priority, with an anti-starvation streak limit that forces an I-cache grant.
// PARAMETERS
//  ADDR_W        16  memory line address width
//  LINE_W        64  cache line data width
//  MAX_D_STREAK  4   consecutive D grants allowed while i_req pending before I is forced (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       reset, asynchronous, active-high
//  i_req      in   1       I-cache read request; held until i_gnt
//  i_addr     in   ADDR_W  I-cache line address, valid with i_req
//  i_gnt      out  1       I request accepted (1-cycle pulse)
//  i_rvalid   out  1       I read data valid (1-cycle pulse)
//  i_rdata    out  LINE_W  I read data
//  d_req      in   1       D-cache request; held until d_gnt
//  d_we       in   1       1=writeback, 0=fill read
//  d_addr     in   ADDR_W  D-cache line address
//  d_wdata    in   LINE_W  writeback data
//  d_gnt      out  1       D request accepted (1-cycle pulse)
//  d_rvalid   out  1       D done (read data valid, or write acked), 1-cycle pulse
//  d_rdata    out  LINE_W  D read data
//  mem_req    out  1       memory request, held until mem_ready
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  LINE_W  memory write data
//  mem_ready  in   1       memory accepts request this cycle
//  mem_rvalid in   1       memory response (read data or write ack)
//  mem_rdata  in   LINE_W  memory read data
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0 and state = IDLE. Streak counter = 0; latched addr/data = 0.
//    Reset mid-transaction abandons it; memory shares rst.
//  - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if any req, pick winner; gnt pulses combinationally this cycle.
//    Latch addr/we/wdata/owner, then go to ISSUE. Requester must drop or replace req the next cycle.
//  - ISSUE: mem_req=1 with latched fields.
//    mem_ready=1 -> WAIT, or RESP directly if mem_rvalid is also 1 that cycle (zero-latency memory).
//  - WAIT: on mem_rvalid, register mem_rdata and go to RESP.
//  - RESP: owner's rvalid=1 with registered rdata, then IDLE.
//    Minimum request-to-rvalid is 3 cycles (gnt in IDLE, ISSUE, RESP). Min gap between grants is 3 cycles.
//  - mem_rvalid outside ISSUE/WAIT is ignored. req during non-IDLE states is ignored (no gnt).
//  - rdata outputs hold their last value outside RESP. On a write (d_we=1), d_rdata is unchanged.
//  - Priority:
//    - d_req only -> D. i_req only -> I.
//    - Both and streak < MAX_D_STREAK -> D, streak++.
//    - Both and streak == MAX_D_STREAK -> I.
//    - Streak clears on any I grant, and on a D grant with i_req=0. Counter width $clog2(MAX_D_STREAK+1), never wraps.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined:
//    - Adds out ports i_wait_cycles[15:0] and d_wait_cycles[15:0].
//    - Each counts cycles where its req=1 and gnt=0. Saturates at 16'hFFFF; cleared by rst.
//  MEM_ARB_STATS_EN undefined: those ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  - nand_cpu_pkg: arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}; arb_owner_t {OWN_I, OWN_D}.
//  - Sub-module mem_arb_priority: combinational winner select plus the streak counter register.
//    Inputs i_req, d_req, take (IDLE & any req); outputs winner.
//  - Top holds the FSM, latches and response registers.
// TESTING
//  1. i_req, addr 0x0040, memory ready at once, rdata 0x..A5 one cycle later
//     -> i_gnt at c0; mem_req c1; i_rvalid c3 with 0x..A5; busy c1-c3.
//  2. i_req and d_req (read) same cycle
//     -> d_gnt first; i_gnt in the IDLE after d_rvalid; i_gnt never with d_gnt.
//  3. MAX_D_STREAK=4; i_req held; d_req back-to-back 6 times
//     -> grants D,D,D,D,I,D; streak resets after the I grant.
//  4. d_we=1, addr 0x0123, wdata 0xDEAD_BEEF_0000_0001; mem_ready low 3 cycles
//     -> mem_req/addr/wdata stable all 4 ISSUE cycles; d_rvalid after ack; d_rdata unchanged.
//  5. mem_ready and mem_rvalid same cycle in ISSUE -> RESP next cycle, rvalid with that data.
//  6. rst asserted in WAIT
//     -> outputs 0 asynchronously; IDLE after release; stray mem_rvalid ignored; stats (if EN) = 0.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, transaction owner,
// and the width of the optional wait-cycle statistics counters.
package nand_cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner select for the memory arbiter: D-cache wins by default, but after
// MAX_D_STREAK consecutive D grants taken over a waiting I-cache, I is forced.
import nand_cpu_pkg::*;

module mem_arb_priority #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       take,
  output arb_owner_t winner
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak;

  always_comb begin
    winner = OWN_I;
    if (d_req && (!i_req || (streak < STREAK_MAX))) winner = OWN_D;
  end

  // Streak only grows while I is actually being passed over; it cannot exceed
  // STREAK_MAX because at that value the winner is forced to I.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (take) begin
      if ((winner == OWN_D) && i_req) streak <= streak + 1'b1;
      else                            streak <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache line fills and D-cache fills/writebacks onto one memory port.
// Optional build macro MEM_ARB_STATS_EN adds saturating per-requester wait-cycle counters.
import nand_cpu_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] i_wait_cycles,
  output logic [STAT_W-1:0] d_wait_cycles
`endif
);

  arb_state_t state;
  arb_owner_t owner;
  arb_owner_t winner;
  logic       we_q;
  logic       take;
  logic       resp_take;

  // Grants are only offered from IDLE and are held off while reset is asserted.
  assign take  = (state == ARB_IDLE) && (i_req || d_req) && !rst;
  assign i_gnt = take && (winner == OWN_I);
  assign d_gnt = take && (winner == OWN_D);

  // A zero-latency memory may accept and answer in the same ISSUE cycle.
  assign resp_take = ((state == ARB_ISSUE) && mem_ready && mem_rvalid) ||
                     ((state == ARB_WAIT) && mem_rvalid);

  mem_arb_priority #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_priority (
    .clk   (clk),
    .rst   (rst),
    .i_req (i_req),
    .d_req (d_req),
    .take  (take),
    .winner(winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_I;
      we_q      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;

      unique case (state)
        ARB_IDLE: begin
          if (take) begin
            owner   <= winner;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            state   <= ARB_ISSUE;
            if (winner == OWN_D) begin
              we_q      <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              we_q      <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= mem_rvalid ? ARB_RESP : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_rvalid) state <= ARB_RESP;
        end
        ARB_RESP: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase

      // Write acks pulse d_rvalid but leave d_rdata holding the last fill.
      if (resp_take) begin
        if (owner == OWN_I) begin
          i_rvalid <= 1'b1;
          i_rdata  <= mem_rdata;
        end else begin
          d_rvalid <= 1'b1;
          if (!we_q) d_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_wait_cycles <= '0;
      d_wait_cycles <= '0;
    end else begin
      if (i_req && !i_gnt) i_wait_cycles <= sat_inc(i_wait_cycles);
      if (d_req && !d_gnt) d_wait_cycles <= sat_inc(d_wait_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with an in-bench memory model and
// a transaction-level reference for grant order, response timing and data.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 64;
  localparam int MAX_D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [LINE_W-1:0] i_rdata, d_rdata;
  logic mem_req, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [LINE_W-1:0] mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] i_wait_cycles, d_wait_cycles;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_D_STREAK(MAX_D)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef MEM_ARB_STATS_EN
    , .i_wait_cycles(i_wait_cycles), .d_wait_cycles(d_wait_cycles)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  // Memory model state
  logic [LINE_W-1:0] mstore [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] refmem [logic [ADDR_W-1:0]];
  int rdy_dly = 0, rsp_dly = 1, mm_wait = 0, mm_rsp = -1;
  logic [LINE_W-1:0] mm_data = '0;
  logic mm_acc = 1'b0, acc_we = 1'b0;
  logic [ADDR_W-1:0] acc_addr = '0;
  logic [LINE_W-1:0] acc_wdata = '0;

  function automatic logic [LINE_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1234};
  endfunction

  function automatic logic [LINE_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return refmem.exists(a) ? refmem[a] : dflt(a);
  endfunction

  task automatic mem_drive();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mm_acc     = 1'b0;
    if (mm_rsp >= 0) begin
      if (mm_rsp == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mm_data;
        mm_rsp     = -1;
      end else begin
        mm_rsp--;
      end
    end else if (mem_req) begin
      if (mm_wait >= rdy_dly) begin
        mem_ready = 1'b1;
        mm_wait   = 0;
        mm_acc    = 1'b1;
        acc_addr  = mem_addr;
        acc_we    = mem_we;
        acc_wdata = mem_wdata;
        if (mem_we) begin
          mstore[mem_addr] = mem_wdata;
          mm_data = {4{16'hBAD0}};
        end else begin
          mm_data = mstore.exists(mem_addr) ? mstore[mem_addr] : dflt(mem_addr);
        end
        if (rsp_dly == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mm_data;
        end else begin
          mm_rsp = rsp_dly - 1;
        end
      end else begin
        mm_wait++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic do_reset();
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    mm_wait = 0; mm_rsp = -1; rdy_dly = 0; rsp_dly = 1;
    mstore.delete();
    refmem.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({i_gnt, d_gnt, mem_req, mem_we, busy, i_rvalid, d_rvalid} !== 7'b0) begin
      nerr++; $display("FAIL reset_ctrl: got %b want 0000000", {i_gnt, d_gnt, mem_req, mem_we, busy, i_rvalid, d_rvalid});
    end
    nvec++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      nerr++; $display("FAIL reset_mem: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    nvec++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      nerr++; $display("FAIL reset_rdata: got %h %h want 0", i_rdata, d_rdata);
    end
`ifdef MEM_ARB_STATS_EN
    nvec++;
    if (i_wait_cycles !== 16'd0 || d_wait_cycles !== 16'd0) begin
      nerr++; $display("FAIL reset_stats: got %h %h want 0", i_wait_cycles, d_wait_cycles);
    end
`endif
    rst = 1'b0;
    #1;
    nvec++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      nerr++; $display("FAIL first_arb: got i/d %b want 01", {i_gnt, d_gnt});
    end
    i_req = 0; d_req = 0;
  endtask

  task automatic test_single_read();
    logic [LINE_W-1:0] v;
    v = 64'h0123_4567_89AB_CDA5;
    do_reset();
    mstore[16'h0040] = v;
    rdy_dly = 0; rsp_dly = 1;
    tick(); i_req = 1; i_addr = 16'h0040; #1;
    nvec++;
    if ({i_gnt, d_gnt, busy} !== 3'b100) begin
      nerr++; $display("FAIL rd_c0: got gnt/busy %b want 100", {i_gnt, d_gnt, busy});
    end
    tick(); i_req = 0; #1;
    nvec++;
    if ({mem_req, mem_we, busy, i_gnt} !== 4'b1010 || mem_addr !== 16'h0040) begin
      nerr++; $display("FAIL rd_c1: got req/we/busy/gnt %b addr %h want 1010 0040", {mem_req, mem_we, busy, i_gnt}, mem_addr);
    end
    tick(); #1;
    nvec++;
    if ({mem_req, busy, i_rvalid} !== 3'b010) begin
      nerr++; $display("FAIL rd_c2: got req/busy/rvalid %b want 010", {mem_req, busy, i_rvalid});
    end
    tick(); #1;
    nvec++;
    if ({i_rvalid, d_rvalid, busy} !== 3'b101 || i_rdata !== v) begin
      nerr++; $display("FAIL rd_c3: got rv %b data %h want 101 %h", {i_rvalid, d_rvalid, busy}, i_rdata, v);
    end
    tick(); #1;
    nvec++;
    if ({i_rvalid, busy} !== 2'b00 || i_rdata !== v) begin
      nerr++; $display("FAIL rd_c4: got rv/busy %b data %h want 00 %h", {i_rvalid, busy}, i_rdata, v);
    end
  endtask

  task automatic test_both();
    int rv_c;
    bit ok;
    do_reset();
    rdy_dly = 0; rsp_dly = 1;
    rv_c = -1; ok = 0;
    tick(); i_req = 1; i_addr = 16'h0111; d_req = 1; d_we = 0; d_addr = 16'h0222; #1;
    nvec++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      nerr++; $display("FAIL both_c0: got i/d %b want 01", {i_gnt, d_gnt});
    end
    for (int c = 1; c < 20 && !ok; c++) begin
      tick(); d_req = 0; #1;
      if (i_gnt && d_gnt) begin
        nvec++; nerr++; $display("FAIL both_dual_gnt: got 11 want not both at c%0d", c);
      end
      if (d_rvalid) begin
        rv_c = c;
        nvec++;
        if (d_rdata !== dflt(16'h0222)) begin
          nerr++; $display("FAIL both_d_data: got %h want %h", d_rdata, dflt(16'h0222));
        end
      end
      if (i_gnt) begin
        ok = 1;
        nvec++;
        if (rv_c < 0 || c != rv_c + 1) begin
          nerr++; $display("FAIL both_i_after_d: got i_gnt c%0d want c%0d", c, rv_c + 1);
        end
      end
    end
    if (!ok) begin
      nvec++; nerr++; $display("FAIL both_timeout: got no i_gnt want i_gnt");
    end
    tick(); i_req = 0; #1;
`ifdef MEM_ARB_STATS_EN
    nvec++;
    if (i_wait_cycles !== 16'd4 || d_wait_cycles !== 16'd0) begin
      nerr++; $display("FAIL both_stats: got %0d %0d want 4 0", i_wait_cycles, d_wait_cycles);
    end
`endif
  endtask

  task automatic test_streak();
    bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int n;
    do_reset();
    rdy_dly = 0; rsp_dly = 0;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      tick(); i_req = 1; i_addr = 16'h0A00; d_req = 1; d_we = 0; d_addr = 16'h0B00; #1;
      if (i_gnt || d_gnt) begin
        nvec++;
        if (d_gnt !== exp_d[n] || i_gnt === d_gnt) begin
          nerr++; $display("FAIL streak_g%0d: got i/d %b want d=%0d", n, {i_gnt, d_gnt}, exp_d[n]);
        end
        n++;
      end
    end
    if (n < 10) begin
      nvec++; nerr++; $display("FAIL streak_timeout: got %0d grants want 10", n);
    end
    i_req = 0; d_req = 0;
  endtask

  task automatic test_write();
    logic [LINE_W-1:0] prior, wd;
    bit ok;
    wd = 64'hDEAD_BEEF_0000_0001;
    do_reset();
    rdy_dly = 0; rsp_dly = 1; ok = 0;
    tick(); d_req = 1; d_we = 0; d_addr = 16'h0300; #1;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick(); d_req = 0; #1;
      if (d_rvalid) ok = 1;
    end
    prior = d_rdata;
    nvec++;
    if (!ok || prior !== dflt(16'h0300)) begin
      nerr++; $display("FAIL wr_prime: got %h want %h", prior, dflt(16'h0300));
    end
    rdy_dly = 3; rsp_dly = 1;
    tick(); d_req = 1; d_we = 1; d_addr = 16'h0123; d_wdata = wd; #1;
    nvec++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      nerr++; $display("FAIL wr_gnt: got i/d %b want 01", {i_gnt, d_gnt});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin d_req = 0; d_we = 0; d_wdata = '0; end
      #1;
      nvec++;
      if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 16'h0123 || mem_wdata !== wd) begin
        nerr++; $display("FAIL wr_issue%0d: got req/we %b addr %h wd %h want 11 0123 %h", k, {mem_req, mem_we}, mem_addr, mem_wdata, wd);
      end
    end
    tick(); #1;
    nvec++;
    if ({mem_req, d_rvalid, busy} !== 3'b001) begin
      nerr++; $display("FAIL wr_wait: got req/rv/busy %b want 001", {mem_req, d_rvalid, busy});
    end
    tick(); #1;
    nvec++;
    if ({d_rvalid, i_rvalid} !== 2'b10 || d_rdata !== prior) begin
      nerr++; $display("FAIL wr_ack: got rv %b data %h want 10 %h", {d_rvalid, i_rvalid}, d_rdata, prior);
    end
    nvec++;
    if (!mstore.exists(16'h0123) || mstore[16'h0123] !== wd) begin
      nerr++; $display("FAIL wr_mem: got missing/wrong data want %h", wd);
    end
  endtask

  task automatic test_zero_latency();
    logic [LINE_W-1:0] v;
    v = 64'hCAFE_F00D_1234_5678;
    do_reset();
    mstore[16'h0555] = v;
    rdy_dly = 0; rsp_dly = 0;
    tick(); i_req = 1; i_addr = 16'h0555; #1;
    nvec++;
    if (i_gnt !== 1'b1) begin
      nerr++; $display("FAIL zl_gnt: got %b want 1", i_gnt);
    end
    tick(); i_req = 0; #1;
    nvec++;
    if ({mem_ready, mem_rvalid, i_rvalid} !== 3'b110) begin
      nerr++; $display("FAIL zl_issue: got rdy/mrv/rv %b want 110", {mem_ready, mem_rvalid, i_rvalid});
    end
    tick(); #1;
    nvec++;
    if ({i_rvalid, busy} !== 2'b11 || i_rdata !== v) begin
      nerr++; $display("FAIL zl_resp: got rv/busy %b data %h want 11 %h", {i_rvalid, busy}, i_rdata, v);
    end
    tick(); #1;
    nvec++;
    if ({i_rvalid, busy} !== 2'b00) begin
      nerr++; $display("FAIL zl_idle: got rv/busy %b want 00", {i_rvalid, busy});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy_dly = 0; rsp_dly = 4;
    tick(); i_req = 1; i_addr = 16'h0777; #1;
    tick(); i_req = 0; #1;
    tick(); #1;
    nvec++;
    if ({busy, mem_req} !== 2'b10) begin
      nerr++; $display("FAIL mid_wait: got busy/req %b want 10", {busy, mem_req});
    end
    #1;
    rst = 1'b1; i_req = 1'b1;
    #1;
    nvec++;
    if ({busy, mem_req, mem_we, i_rvalid, d_rvalid, i_gnt, d_gnt} !== 7'b0 || mem_addr !== '0) begin
      nerr++; $display("FAIL mid_async: got %b addr %h want 0000000 0000", {busy, mem_req, mem_we, i_rvalid, d_rvalid, i_gnt, d_gnt}, mem_addr);
    end
`ifdef MEM_ARB_STATS_EN
    nvec++;
    if (i_wait_cycles !== 16'd0 || d_wait_cycles !== 16'd0) begin
      nerr++; $display("FAIL mid_stats: got %h %h want 0", i_wait_cycles, d_wait_cycles);
    end
`endif
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0; mm_rsp = -1; mm_wait = 0;
    tick(); mem_rvalid = 1'b1; mem_rdata = {4{16'hEEEE}}; #1;
    nvec++;
    if ({busy, i_gnt, d_gnt} !== 3'b000) begin
      nerr++; $display("FAIL mid_idle: got busy/gnt %b want 000", {busy, i_gnt, d_gnt});
    end
    tick(); #1;
    nvec++;
    if ({i_rvalid, d_rvalid, busy} !== 3'b000 || i_rdata !== '0) begin
      nerr++; $display("FAIL mid_stray: got rv/busy %b data %h want 000 0", {i_rvalid, d_rvalid, busy}, i_rdata);
    end
    tick(); i_req = 1; i_addr = 16'h0042; #1;
    nvec++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      nerr++; $display("FAIL mid_regrant: got i/d %b want 10", {i_gnt, d_gnt});
    end
    i_req = 0;
  endtask

  task automatic test_random();
    int streak, age, iw, dw;
    bit outst, own_d, o_we, resp_due, mrv, eg_i, eg_d, ip, dp, dwe;
    logic [ADDR_W-1:0] o_addr, ia, da;
    logic [LINE_W-1:0] o_wdata, exp_rd, last_d, dwd;
    do_reset();
    streak = 0; age = 0; iw = 0; dw = 0;
    outst = 0; own_d = 0; o_we = 0; resp_due = 0; ip = 0; dp = 0; dwe = 0;
    o_addr = '0; ia = '0; da = '0; o_wdata = '0; exp_rd = '0; last_d = '0; dwd = '0;
    for (int c = 0; c < 600; c++) begin
      tick();
      mrv = mem_rvalid;
      if (mm_acc) begin
        nvec++;
        if (acc_addr !== o_addr || acc_we !== o_we || (o_we && acc_wdata !== o_wdata)) begin
          nerr++; $display("FAIL rnd_mem_fields: got %h/%b/%h want %h/%b/%h", acc_addr, acc_we, acc_wdata, o_addr, o_we, o_wdata);
        end
      end
      if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; ia = 16'($urandom); end
      if (!dp && $urandom_range(0, 1) == 0) begin
        dp = 1; da = 16'($urandom_range(0, 31)); dwe = 1'($urandom); dwd = {$urandom, $urandom};
      end
      i_req = ip; i_addr = ia; d_req = dp; d_addr = da; d_we = dwe; d_wdata = dwd;
      #1;
      nvec++;
      if (busy !== outst) begin
        nerr++; $display("FAIL rnd_busy: got %b want %b at c%0d", busy, outst, c);
      end
      nvec++;
      if ({i_rvalid, d_rvalid} !== {resp_due && !own_d, resp_due && own_d}) begin
        nerr++; $display("FAIL rnd_rvalid: got %b want %b at c%0d", {i_rvalid, d_rvalid}, {resp_due && !own_d, resp_due && own_d}, c);
      end
      if (resp_due) begin
        nvec++;
        if (!own_d && i_rdata !== exp_rd) begin
          nerr++; $display("FAIL rnd_i_data: got %h want %h", i_rdata, exp_rd);
        end else if (own_d && !o_we && d_rdata !== exp_rd) begin
          nerr++; $display("FAIL rnd_d_data: got %h want %h", d_rdata, exp_rd);
        end else if (own_d && o_we && d_rdata !== last_d) begin
          nerr++; $display("FAIL rnd_d_hold: got %h want %h", d_rdata, last_d);
        end
        if (own_d && !o_we) last_d = exp_rd;
      end
      eg_i = 0; eg_d = 0;
      if (!outst) begin
        if (dp && !ip)      eg_d = 1;
        else if (ip && !dp) eg_i = 1;
        else if (ip && dp) begin
          if (streak < MAX_D) eg_d = 1;
          else                eg_i = 1;
        end
      end
      nvec++;
      if ({i_gnt, d_gnt} !== {eg_i, eg_d}) begin
        nerr++; $display("FAIL rnd_gnt: got i/d %b want %b at c%0d streak %0d", {i_gnt, d_gnt}, {eg_i, eg_d}, c, streak);
      end
      if (ip && !i_gnt) iw++;
      if (dp && !d_gnt) dw++;
      if (resp_due) begin outst = 0; resp_due = 0; end
      else if (mrv && outst) resp_due = 1;
      if (eg_i || eg_d) begin
        outst = 1; own_d = eg_d; age = 0;
        if (eg_i) streak = 0;
        else      streak = ip ? streak + 1 : 0;
        if (eg_d) begin
          o_addr = da; o_we = dwe; o_wdata = dwd;
          if (dwe) refmem[da] = dwd;
          else     exp_rd = ref_rd(da);
          dp = 0;
        end else begin
          o_addr = ia; o_we = 0; o_wdata = '0;
          exp_rd = ref_rd(ia);
          ip = 0;
        end
        rdy_dly = $urandom_range(0, 3);
        rsp_dly = $urandom_range(0, 3);
      end
      if (outst) age++;
      if (age > 40) begin
        nvec++; nerr++; $display("FAIL rnd_timeout: got no response after %0d cycles want <=40", age);
        break;
      end
    end
`ifdef MEM_ARB_STATS_EN
    @(posedge clk);
    #1;
    nvec++;
    if (i_wait_cycles !== 16'(iw) || d_wait_cycles !== 16'(dw)) begin
      nerr++; $display("FAIL rnd_stats: got %0d %0d want %0d %0d", i_wait_cycles, d_wait_cycles, iw, dw);
    end
`endif
    i_req = 0; d_req = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_both();
    test_streak();
    test_write();
    test_zero_latency();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
